// File: rtl/moving_sum_if.sv
// Sample/result bundle for moving_sum: new and delayed sample strobes in,
// registered window sum and status out.
interface moving_sum_if #(
    parameter int WIDTH  = 10,
    parameter int WINDOW = 40
);
    localparam int SUM_W = WIDTH + $clog2(WINDOW + 1);

    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             d_valid;
    logic [WIDTH-1:0] d_data;
    logic             o_valid;
    logic [SUM_W-1:0] o_sum;
    logic             o_full;
    logic             o_err;

    modport master (
        output i_valid, i_data, d_valid, d_data,
        input  o_valid, o_sum, o_full, o_err
    );

    modport slave (
        input  i_valid, i_data, d_valid, d_data,
        output o_valid, o_sum, o_full, o_err
    );
endinterface

// File: rtl/moving_sum.sv
// Running sum over the last WINDOW samples, fed by a sample stream and its delayed copy.
// Define MOVING_SUM_CHECK_EN to build in the sticky protocol checker behind o_err.
module moving_sum #(
    parameter int WIDTH  = 10,
    parameter int WINDOW = 40
) (
    input  logic         clk,
    input  logic         reset,
    moving_sum_if.slave  bus
);
    localparam int SUM_W = WIDTH + $clog2(WINDOW + 1);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WINDOW);

    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_next;
    logic [SUM_W-1:0] add_term;
    logic [SUM_W-1:0] sub_term;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             steady;

    assign steady = (cnt == CNT_MAX);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        add_term = SUM_W'(bus.i_data);
        sub_term = '0;
        if (bus.d_valid) begin
            sub_term = SUM_W'(bus.d_data);
        end
        acc_next = acc + add_term - sub_term;
        cnt_next = cnt;
        if (!steady) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            cnt         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_full  <= 1'b0;
        end else begin
            bus.o_valid <= bus.i_valid;
            if (bus.i_valid) begin
                acc        <= acc_next;
                cnt        <= cnt_next;
                bus.o_full <= (cnt_next == CNT_MAX);
            end
        end
    end

    // acc only moves on accepted samples, so it doubles as the held output register.
    assign bus.o_sum = acc;

`ifdef MOVING_SUM_CHECK_EN
    logic err;
    logic violation;

    // The cycle that fills the window is still FILLING, so its d_valid must be low.
    always_comb begin
        violation = 1'b0;
        if (bus.d_valid && !bus.i_valid) begin
            violation = 1'b1;
        end else if (bus.i_valid && (bus.d_valid != steady)) begin
            violation = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (violation) begin
            err <= 1'b1;
        end
    end

    assign bus.o_err = err;
`else
    assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_moving_sum.sv
// Directed bench for moving_sum: WINDOW=4 and WINDOW=1 instances, expected
// sums queued when a sample is driven and compared when o_valid returns.
module tb_moving_sum;
    logic clk;
    logic reset;

    moving_sum_if #(.WIDTH(8), .WINDOW(4)) b4 ();
    moving_sum_if #(.WIDTH(8), .WINDOW(1)) b1 ();

    moving_sum #(.WIDTH(8), .WINDOW(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    moving_sum #(.WIDTH(8), .WINDOW(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    typedef struct {
        int sum;
        bit full;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   last_sum;
    bit   last_full;
    bit   exp_err;

`ifdef MOVING_SUM_CHECK_EN
    localparam bit CHECKER_ON = 1'b1;
`else
    localparam bit CHECKER_ON = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic drive(input bit sel, input bit iv, input logic [7:0] id,
                         input bit dv, input logic [7:0] dd);
        b4.i_valid = sel ? 1'b0 : iv;
        b4.i_data  = sel ? 8'd0 : id;
        b4.d_valid = sel ? 1'b0 : dv;
        b4.d_data  = sel ? 8'd0 : dd;
        b1.i_valid = sel ? iv : 1'b0;
        b1.i_data  = sel ? id : 8'd0;
        b1.d_valid = sel ? dv : 1'b0;
        b1.d_data  = sel ? dd : 8'd0;
    endtask

    // One clock: drive, edge, then sample 1 time unit later.
    task automatic step(input bit sel, input bit iv, input logic [7:0] id,
                        input bit dv, input logic [7:0] dd,
                        input int es, input bit ef);
        logic        ov;
        logic [31:0] os;
        logic        of;
        logic        oe;
        exp_t        e;
        drive(sel, iv, id, dv, dd);
        if (iv) q.push_back('{sum: es, full: ef});
        @(posedge clk);
        #1;
        ov = sel ? b1.o_valid : b4.o_valid;
        os = sel ? 32'(b1.o_sum) : 32'(b4.o_sum);
        of = sel ? b1.o_full : b4.o_full;
        oe = sel ? b1.o_err : b4.o_err;
        chk("o_valid", 32'(ov), 32'(iv));
        if (ov === 1'b1) begin
            if (q.size() == 0) begin
                chk("scoreboard_nonempty", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("o_sum", os, 32'(e.sum));
                chk("o_full", 32'(of), 32'(e.full));
                last_sum  = e.sum;
                last_full = e.full;
            end
        end else begin
            chk("o_sum_hold", os, 32'(last_sum));
            chk("o_full_hold", 32'(of), 32'(last_full));
        end
        chk("o_err", 32'(oe), 32'(exp_err));
    endtask

    task automatic idle(input bit sel, input int n);
        for (int i = 0; i < n; i++) step(sel, 1'b0, 8'd0, 1'b0, 8'd0, 0, 1'b0);
    endtask

    // Reset with a live sample on the selected bus; the sample must vanish.
    task automatic do_reset(input bit sel);
        reset = 1'b1;
        drive(sel, 1'b1, 8'd5, 1'b1, 8'd3);
        @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(sel ? b1.o_valid : b4.o_valid), 32'd0);
        chk("rst_o_sum", sel ? 32'(b1.o_sum) : 32'(b4.o_sum), 32'd0);
        chk("rst_o_full", 32'(sel ? b1.o_full : b4.o_full), 32'd0);
        chk("rst_o_err", 32'(sel ? b1.o_err : b4.o_err), 32'd0);
        reset = 1'b0;
        q.delete();
        last_sum  = 0;
        last_full = 1'b0;
        exp_err   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        last_sum = 0; last_full = 1'b0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // Back-to-back fill then steady: 1,3,6,10,14,18.
        step(0, 1, 8'd1, 0, 8'd0, 1, 0);
        step(0, 1, 8'd2, 0, 8'd0, 3, 0);
        step(0, 1, 8'd3, 0, 8'd0, 6, 0);
        step(0, 1, 8'd4, 0, 8'd0, 10, 1);
        step(0, 1, 8'd5, 1, 8'd1, 14, 1);
        step(0, 1, 8'd6, 1, 8'd2, 18, 1);
        idle(0, 2);

        // Same stream with 3-cycle gaps: identical sums, held outputs in gaps.
        do_reset(1'b0);
        step(0, 1, 8'd1, 0, 8'd0, 1, 0);  idle(0, 3);
        step(0, 1, 8'd2, 0, 8'd0, 3, 0);  idle(0, 3);
        step(0, 1, 8'd3, 0, 8'd0, 6, 0);  idle(0, 3);
        step(0, 1, 8'd4, 0, 8'd0, 10, 1); idle(0, 3);
        step(0, 1, 8'd5, 1, 8'd1, 14, 1); idle(0, 3);
        step(0, 1, 8'd6, 1, 8'd2, 18, 1); idle(0, 3);

        // Full-scale samples: 1020 fits in 11 bits and stays steady.
        do_reset(1'b0);
        step(0, 1, 8'd255, 0, 8'd0, 255, 0);
        step(0, 1, 8'd255, 0, 8'd0, 510, 0);
        step(0, 1, 8'd255, 0, 8'd0, 765, 0);
        step(0, 1, 8'd255, 0, 8'd0, 1020, 1);
        step(0, 1, 8'd255, 1, 8'd255, 1020, 1);
        step(0, 1, 8'd255, 1, 8'd255, 1020, 1);

        // Mid-stream reset after the third sample, then restart at 7.
        do_reset(1'b0);
        step(0, 1, 8'd1, 0, 8'd0, 1, 0);
        step(0, 1, 8'd2, 0, 8'd0, 3, 0);
        step(0, 1, 8'd3, 0, 8'd0, 6, 0);
        do_reset(1'b0);
        step(0, 1, 8'd7, 0, 8'd0, 7, 0);
        idle(0, 1);

        // Protocol violation while filling: arithmetic unchanged, o_err sticky if built in.
        do_reset(1'b0);
        step(0, 1, 8'd1, 0, 8'd0, 1, 0);
        exp_err = CHECKER_ON;
        step(0, 1, 8'd2, 1, 8'd1, 2, 0);
        idle(0, 4);
        step(0, 1, 8'd3, 0, 8'd0, 5, 0);
        do_reset(1'b0);
        step(0, 1, 8'd4, 0, 8'd0, 4, 0);

        // WINDOW=1: full from the first output, sum tracks the current sample.
        do_reset(1'b1);
        step(1, 1, 8'd9, 0, 8'd0, 9, 1);
        step(1, 1, 8'd4, 1, 8'd9, 4, 1);
        idle(1, 2);
        step(1, 1, 8'd200, 1, 8'd4, 200, 1);

        drive(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
